// File: rtl/frame_serializer.sv
// Frame serializer: captures DEPTH words of {addr_in, data_in} after a rising
// edge on ena, then streams them out one bit per cycle with valid/last flags.
module frame_serializer #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ena_out,
  output logic              data_out,
  output logic              last,
  output logic              busy
);

  localparam int W   = ADDR_W + DATA_W;
  localparam int WCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BCW = (W > 1) ? $clog2(W) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(DEPTH - 1);
  localparam logic [BCW-1:0] BLAST = BCW'(W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   mem [DEPTH];
  logic [WCW-1:0] wcnt, wcnt_nx;
  logic [BCW-1:0] bcnt, bcnt_nx;
  logic [BCW-1:0] bidx;
  logic [W-1:0]   cur_word;
  logic           ena_q, start, wr_en;
  logic           data_nx, ena_out_nx, last_nx;

  assign start    = ena & ~ena_q;
  assign cur_word = mem[wcnt];
  assign bidx     = (MSB_FIRST != 0) ? BLAST - bcnt : bcnt;

  always_comb begin
    state_nx   = state;
    wcnt_nx    = wcnt;
    bcnt_nx    = bcnt;
    wr_en      = 1'b0;
    data_nx    = 1'b0;
    ena_out_nx = 1'b0;
    last_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          wcnt_nx  = '0;
          bcnt_nx  = '0;
        end
      end
      LOAD: begin
        wr_en = 1'b1;
        if (wcnt == WLAST) begin
          state_nx = SHIFT;
          wcnt_nx  = '0;
          bcnt_nx  = '0;
        end else begin
          wcnt_nx = wcnt + 1'b1;
        end
      end
      SHIFT: begin
        data_nx    = cur_word[bidx];
        ena_out_nx = 1'b1;
        // Explicit terminal compares keep non-power-of-two sizes from overrunning.
        if (bcnt == BLAST) begin
          bcnt_nx = '0;
          if (wcnt == WLAST) begin
            last_nx  = 1'b1;
            state_nx = IDLE;
            wcnt_nx  = '0;
          end else begin
            wcnt_nx = wcnt + 1'b1;
          end
        end else begin
          bcnt_nx = bcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      bcnt     <= '0;
      ena_q    <= 1'b0;
      ena_out  <= 1'b0;
      data_out <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      wcnt     <= wcnt_nx;
      bcnt     <= bcnt_nx;
      ena_q    <= ena;
      ena_out  <= ena_out_nx;
      data_out <= data_nx;
      last     <= last_nx;
      busy     <= (state_nx != IDLE);
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wcnt] <= {addr_in, data_in};
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: three configurations driven from shared stimulus,
// checked every cycle against a frame-age model plus literal stream checks.
module tb_frame_serializer;

  localparam int N = 3;
  localparam int DEP [N] = '{16, 3, 5};
  localparam int WID [N] = '{8, 5, 3};
  localparam int MSB [N] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] stim;
  logic [N-1:0] eo, dout, lst, bsy;

  always #5 clk = ~clk;

  frame_serializer #(.ADDR_W(4), .DATA_W(4), .DEPTH(16), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .addr_in(stim[7:4]), .data_in(stim[3:0]),
    .ena_out(eo[0]), .data_out(dout[0]), .last(lst[0]), .busy(bsy[0]));
  frame_serializer #(.ADDR_W(2), .DATA_W(3), .DEPTH(3), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .addr_in(stim[4:3]), .data_in(stim[2:0]),
    .ena_out(eo[1]), .data_out(dout[1]), .last(lst[1]), .busy(bsy[1]));
  frame_serializer #(.ADDR_W(1), .DATA_W(2), .DEPTH(5), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .addr_in(stim[2:2]), .data_in(stim[1:0]),
    .ena_out(eo[2]), .data_out(dout[2]), .last(lst[2]), .busy(bsy[2]));

  int errs = 0, checks = 0, cyc = 0;
  bit m_act [N];
  bit m_ep [N];
  int m_age [N];
  logic [7:0] m_w [N][16];
  logic x_eo [N], x_d [N], x_l [N], x_b [N];

  int obs_cnt [N], last_cnt [N], last_pos [N], first_eo [N];
  logic [127:0] obs_bits [N];
  logic bsy_at_last [N];
  int epoch = 0, seen_epoch = 0;

  string lit_name [64];
  int lit_act [64], lit_exp [64];
  int lit_n = 0, lit_done = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    lit_name[lit_n] = nm;
    lit_act[lit_n]  = act;
    lit_exp[lit_n]  = exp;
    lit_n++;
  endtask

  // Model: a frame is a start edge, DEPTH capture edges, then DEPTH*W bit edges.
  always @(posedge clk) begin : cmp
    int n, wd, b, idx;
    bit st;
    cyc++;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      for (int k = 0; k < N; k++) begin
        obs_cnt[k] = 0; last_cnt[k] = 0; last_pos[k] = -1; first_eo[k] = -1;
        obs_bits[k] = '0; bsy_at_last[k] = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      x_eo[k] = 1'b0; x_d[k] = 1'b0; x_l[k] = 1'b0;
      if (!rst_n) begin
        m_act[k] = 1'b0;
        m_ep[k]  = 1'b0;
      end else begin
        st = ena && !m_ep[k];
        m_ep[k] = ena;
        if (!m_act[k]) begin
          if (st) begin
            m_act[k] = 1'b1;
            m_age[k] = 0;
          end
        end else begin
          m_age[k]++;
          if (m_age[k] <= DEP[k]) begin
            m_w[k][m_age[k]-1] = stim;
          end else begin
            n   = m_age[k] - DEP[k] - 1;
            wd  = n / WID[k];
            b   = n % WID[k];
            idx = (MSB[k] != 0) ? WID[k] - 1 - b : b;
            x_d[k]  = m_w[k][wd][idx];
            x_eo[k] = 1'b1;
            if (n == DEP[k] * WID[k] - 1) begin
              x_l[k]   = 1'b1;
              m_act[k] = 1'b0;
            end
          end
        end
      end
      x_b[k] = m_act[k];
    end
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("ena_out[%0d]", k), int'(eo[k]), int'(x_eo[k]));
      check($sformatf("data_out[%0d]", k), int'(dout[k]), int'(x_d[k]));
      check($sformatf("last[%0d]", k), int'(lst[k]), int'(x_l[k]));
      check($sformatf("busy[%0d]", k), int'(bsy[k]), int'(x_b[k]));
      if (eo[k]) begin
        if (obs_cnt[k] == 0) first_eo[k] = cyc;
        if (obs_cnt[k] < 128) obs_bits[k][obs_cnt[k]] = dout[k];
        obs_cnt[k]++;
      end
      if (lst[k]) begin
        last_cnt[k]++;
        last_pos[k]    = obs_cnt[k] - 1;
        bsy_at_last[k] = bsy[k];
      end
    end
    while (lit_done < lit_n) begin
      check(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
      lit_done++;
    end
  end

  task automatic tick(input logic e, input logic [7:0] s);
    @(negedge clk);
    ena  = e;
    stim = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      stim = 8'($urandom);
    end
  endtask

  task automatic new_epoch();
    @(negedge clk);
    epoch++;
  endtask

  initial begin : stim_proc
    bit found;
    int start_c;
    rst_n = 1'b0; ena = 1'b0; stim = '0;
    repeat (3) @(negedge clk);
    #2 lit("reset_outputs", int'({eo, dout, lst, bsy}), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // Default frame with word i = {i, ~i}.
    new_epoch();
    tick(1'b1, 8'($urandom));
    for (int i = 0; i < 16; i++) tick(1'b1, {4'(i), ~4'(i)});
    tick(1'b0, 8'($urandom));
    idle(140);
    lit("a_valid_bits", obs_cnt[0], 128);
    lit("a_first_byte", int'(obs_bits[0][7:0]), 'h0F);
    lit("a_last_count", last_cnt[0], 1);
    lit("a_last_pos", last_pos[0], 127);
    lit("a_busy_at_last", int'(bsy_at_last[0]), 0);
    lit("c_valid_bits", obs_cnt[2], 15);
    lit("c_last_count", last_cnt[2], 1);
    lit("c_last_pos", last_pos[2], 14);

    // MSB-first DEPTH=3 pattern.
    new_epoch();
    tick(1'b1, 8'($urandom));
    tick(1'b1, 8'h16);
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h1F);
    tick(1'b0, 8'($urandom));
    idle(150);
    lit("b_valid_bits", obs_cnt[1], 15);
    lit("b_stream", int'(obs_bits[1][14:0]), 'h7E0D);
    lit("b_last_count", last_cnt[1], 1);

    // ena pulses mid-SHIFT and on the last-bit edge of the long frame.
    new_epoch();
    tick(1'b1, 8'($urandom));
    repeat (16) tick(1'b0, 8'($urandom));
    idle(30);
    tick(1'b1, 8'($urandom));
    tick(1'b0, 8'($urandom));
    idle(95);
    tick(1'b1, 8'($urandom));
    tick(1'b0, 8'($urandom));
    idle(150);
    lit("ignored_start_bits", obs_cnt[0], 128);
    lit("ignored_start_last", last_cnt[0], 1);

    // Asynchronous reset near bit 40, released with ena already high.
    new_epoch();
    tick(1'b1, 8'($urandom));
    tick(1'b0, 8'($urandom));
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (obs_cnt[0] >= 40) found = 1'b1;
      else tick(1'b0, 8'($urandom));
    end
    lit("reach_bit40", int'(found), 1);
    #2 rst_n = 1'b0;
    ena = 1'b1;
    #1 lit("async_reset_outputs", int'({eo, dout, lst, bsy}), 0);
    @(negedge clk);
    epoch++;
    rst_n = 1'b1;
    idle(160);
    lit("post_reset_bits", obs_cnt[0], 128);
    lit("post_reset_last", last_cnt[0], 1);
    lit("held_ena_c_once", obs_cnt[2], 15);

    // ena dropped then raised again: latency from the detecting edge.
    @(negedge clk);
    epoch++;
    ena = 1'b0;
    tick(1'b1, 8'($urandom));
    start_c = cyc + 1;
    idle(160);
    for (int k = 0; k < N; k++)
      lit($sformatf("latency[%0d]", k), first_eo[k] - start_c, DEP[k] + 1);
    lit("restart_bits", obs_cnt[0], 128);

    // Random ena toggling, data and occasional resets.
    ena = 1'b0;
    repeat (1500) begin
      @(negedge clk);
      stim = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ena = ~ena;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    idle(5);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
